uart_fifo: RTL



---
 rtl/uart_fifo.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo.sv
// Memory-mapped 8N1 UART with programmable baud divisor, TX/RX FIFOs,
// sticky receive error flags and an RX-not-empty interrupt.
module uart_fifo #(
  parameter int BAUD_DIV = 27,
  parameter int FIFO_AW  = 4,
  parameter int DIV_W    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        tx,
  input  logic        rx
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [DIV_W-1:0]   DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0]   DIV_MIN  = DIV_W'(2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Bus decode
  logic wr_data, wr_status, wr_div;
  assign wr_data   = sel & we & (addr == 2'd0);
  assign wr_status = sel & we & (addr == 2'd1);
  assign wr_div    = sel & we & (addr == 2'd2);

  logic unused_wdata;
  assign unused_wdata = ^wdata;

  logic [DIV_W-1:0] divisor;
  logic             rx_ovr, frm_err, irq_q;

  // FIFO storage
  logic [7:0]         tx_mem [DEPTH];
  logic [7:0]         rx_mem [DEPTH];
  logic [FIFO_AW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic [FIFO_AW:0]   tx_count, rx_count;
  logic               tx_full, tx_fifo_empty, rx_full, rx_avail;
  logic               tx_push, tx_pop, rx_push, rx_pop;

  assign tx_full       = (tx_count == CNT_FULL);
  assign tx_fifo_empty = (tx_count == '0);
  assign rx_full       = (rx_count == CNT_FULL);
  assign rx_avail      = (rx_count != '0);

  // TX signals
  state_t           tx_state, tx_state_next;
  logic [DIV_W-1:0] tx_d, tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shreg;
  logic             tx_q, tx_busy_q, tx_tick, tx_level, tx_busy, tx_empty;

  // RX signals
  state_t           rx_state, rx_state_next;
  logic [DIV_W-1:0] rx_d, rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shreg;
  logic             rx_s1, rx_s2, rx_prev, rx_fall;
  logic             rx_restart, rx_shift, rx_push_req, frm_set, ovr_set;

  assign tx_push = wr_data & (~tx_full | tx_pop);
  assign rx_pop  = sel & re & (addr == 2'd0) & rx_avail;
  assign rx_push = rx_push_req & (~rx_full | rx_pop);
  assign ovr_set = rx_push_req & rx_full & ~rx_pop;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= wdata[7:0];
    if (rx_push) rx_mem[rx_wptr] <= rx_shreg;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
      if (tx_pop)  tx_rptr <= tx_rptr + PTR_ONE;
      if (tx_push && !tx_pop)      tx_count <= tx_count + CNT_ONE;
      else if (!tx_push && tx_pop) tx_count <= tx_count - CNT_ONE;
      if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
      if (rx_pop)  rx_rptr <= rx_rptr + PTR_ONE;
      if (rx_push && !rx_pop)      rx_count <= rx_count + CNT_ONE;
      else if (!rx_push && rx_pop) rx_count <= rx_count - CNT_ONE;
    end
  end

  // Control registers; a flag being set wins over a clear on the same edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      divisor <= DIV_W'(BAUD_DIV);
      rx_ovr  <= 1'b0;
      frm_err <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (wr_div)
        divisor <= (wdata[DIV_W-1:0] < DIV_MIN) ? DIV_MIN : wdata[DIV_W-1:0];
      rx_ovr  <= ovr_set | (rx_ovr  & ~(wr_status & wdata[5]));
      frm_err <= frm_set | (frm_err & ~(wr_status & wdata[6]));
      irq_q   <= rx_avail;
    end
  end

  // TX FSM
  always_ff @(posedge clk) begin
    if (!reset_n) tx_state <= IDLE;
    else          tx_state <= tx_state_next;
  end

  always_comb begin
    tx_state_next = tx_state;
    tx_pop        = 1'b0;
    tx_level      = 1'b1;
    tx_tick       = (tx_cnt == tx_d - DIV_ONE);
    case (tx_state)
      IDLE: begin
        if (!tx_fifo_empty) begin
          tx_pop        = 1'b1;
          tx_state_next = START;
        end
      end
      START: begin
        tx_level = 1'b0;
        if (tx_tick) tx_state_next = DATA;
      end
      DATA: begin
        tx_level = tx_shreg[0];
        if (tx_tick && tx_bit == 3'd7) tx_state_next = STOP;
      end
      STOP: begin
        if (tx_tick) begin
          if (!tx_fifo_empty) begin
            tx_pop        = 1'b1;
            tx_state_next = START;
          end else begin
            tx_state_next = IDLE;
          end
        end
      end
      default: tx_state_next = IDLE;
    endcase
  end

  // tx is registered from the state's level, so the line trails the state by one edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_q      <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shreg  <= '0;
      tx_d      <= DIV_W'(BAUD_DIV);
    end else begin
      tx_q      <= tx_level;
      tx_busy_q <= (tx_state != IDLE);
      tx_cnt    <= (tx_state == IDLE || tx_tick) ? '0 : tx_cnt + DIV_ONE;
      if (tx_pop) begin
        tx_shreg <= tx_mem[tx_rptr];
        tx_d     <= divisor;
        tx_bit   <= '0;
      end else if (tx_state == DATA && tx_tick) begin
        tx_shreg <= {1'b0, tx_shreg[7:1]};
        tx_bit   <= tx_bit + 3'd1;
      end
    end
  end

  assign tx_busy  = (tx_state != IDLE) | tx_busy_q;
  assign tx_empty = tx_fifo_empty & ~tx_busy;
  assign tx       = tx_q;

  // RX FSM
  assign rx_fall = rx_prev & ~rx_s2;

  always_ff @(posedge clk) begin
    if (!reset_n) rx_state <= IDLE;
    else          rx_state <= rx_state_next;
  end

  always_comb begin
    rx_state_next = rx_state;
    rx_restart    = 1'b0;
    rx_shift      = 1'b0;
    rx_push_req   = 1'b0;
    frm_set       = 1'b0;
    case (rx_state)
      IDLE: begin
        if (rx_fall) rx_state_next = START;
      end
      START: begin
        if (rx_cnt == (rx_d >> 1) - DIV_ONE) begin
          rx_restart    = 1'b1;
          rx_state_next = rx_s2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (rx_cnt == rx_d - DIV_ONE) begin
          rx_restart = 1'b1;
          rx_shift   = 1'b1;
          if (rx_bit == 3'd7) rx_state_next = STOP;
        end
      end
      STOP: begin
        if (rx_cnt == rx_d - DIV_ONE) begin
          rx_restart    = 1'b1;
          rx_push_req   = rx_s2;
          frm_set       = ~rx_s2;
          rx_state_next = IDLE;
        end
      end
      default: rx_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shreg <= '0;
      rx_d     <= DIV_W'(BAUD_DIV);
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_cnt  <= (rx_state == IDLE || rx_restart) ? '0 : rx_cnt + DIV_ONE;
      if (rx_state == IDLE && rx_fall) begin
        rx_d   <= divisor;
        rx_bit <= '0;
      end
      if (rx_shift) begin
        rx_shreg <= {rx_s2, rx_shreg[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
    end
  end

  assign irq = irq_q;

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0: rdata[7:0] = rx_mem[rx_rptr];
      2'd1: begin
        rdata[6:0]  = {frm_err, rx_ovr, tx_busy, rx_full, rx_avail, tx_full, tx_empty};
        rdata[15:8] = 8'(rx_count);
      end
      2'd2: rdata[DIV_W-1:0] = divisor;
      default: rdata = '0;
    endcase
  end

endmodule
